// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with a circular return-address stack.
// Next-pc priority is branch > jump (optionally call) > return > sequential.
// Optional feature: define PC_REDIRECT_CNT_EN to add a saturating redirect_cnt output
// that counts non-sequential pc updates.
module pc_sequencer #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        call,
  input  logic        ret,
  input  logic [31:0] ret_fallback,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_ovf
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The pointer wraps naturally because RAS_DEPTH is a power of two, so a push
  // onto a full stack overwrites the oldest entry without extra logic.
  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;

  logic [31:0] next_pc;
  logic        do_push;
  logic        do_pop;

  assign pc_plus1  = pc + 32'd1;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));

  // Arbitrate the next pc and decide stack side effects; losers have no effect.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_pc = pc_plus1;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (branch_taken) begin
      next_pc = branch_target;
    end else if (jump) begin
      next_pc = jump_target;
      do_push = call & ~stall;
    end else if (ret) begin
      if (!ras_empty) begin
        next_pc = ras_mem[top];
        do_pop  = ~stall;
      end else begin
        next_pc = ret_fallback;
      end
    end
  end

  // Stack entry storage: written on push, never reset (count/top define validity).
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately left out of reset; stale entries are never read.
    if (rst_n && do_push) begin
      ras_mem[top + PTR_W'(1)] <= pc_plus1;
    end
  end

  // PC, stack pointer, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      pc      <= RESET_PC;
      top     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
    end else if (!stall) begin
      pc <= next_pc;
      if (do_push) begin
        top <= top + PTR_W'(1);
        if (!ras_full) begin
          count <= count + CNT_W'(1);
        end else begin
          ras_ovf <= 1'b1;
        end
      end else if (do_pop) begin
        top   <= top - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic redirect;
  assign redirect = ~stall & (branch_taken | jump | ret);

  // Saturating count of non-sequential pc updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (redirect && redirect_cnt != 16'hFFFF) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the pc and return-address stack.
module tb_pc_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        call;
  logic        ret;
  logic [31:0] ret_fallback;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RAS_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .ret_fallback  (ret_fallback),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_ovf       (ras_ovf)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt  (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: newest return address at the back of the queue.
  logic [31:0] pc_m;
  logic [31:0] ras_q[$];
  bit          ovf_m;
  bit          model_valid = 1'b0;
  int unsigned rc_m;

  always @(posedge clk) begin
    if (!rst_n) begin
      pc_m = RESET_PC;
      ras_q.delete();
      ovf_m = 1'b0;
      rc_m = 0;
      model_valid = 1'b1;
    end else if (model_valid && !stall) begin
      if (branch_taken || jump || ret) rc_m = (rc_m == 16'hFFFF) ? rc_m : rc_m + 1;
      if (branch_taken) begin
        pc_m = branch_target;
      end else if (jump) begin
        if (call) begin
          ras_q.push_back(pc_m + 32'd1);
          if (ras_q.size() > DEPTH) begin
            void'(ras_q.pop_front());
            ovf_m = 1'b1;
          end
        end
        pc_m = jump_target;
      end else if (ret) begin
        if (ras_q.size() > 0) pc_m = ras_q.pop_back();
        else pc_m = ret_fallback;
      end else begin
        pc_m = pc_m + 32'd1;
      end
    end
    if (model_valid) begin
      #1;
      check("pc", pc, pc_m);
      check("pc_plus1", pc_plus1, pc_m + 32'd1);
      check("ras_empty", 32'(ras_empty), 32'(ras_q.size() == 0));
      check("ras_full", 32'(ras_full), 32'(ras_q.size() == DEPTH));
      check("ras_ovf", 32'(ras_ovf), 32'(ovf_m));
`ifdef PC_REDIRECT_CNT_EN
      check("redirect_cnt", 32'(redirect_cnt), rc_m);
`endif
    end
  end

  task automatic idle();
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0; ret_fallback = '0;
  endtask

  // Advance one edge; returns after the model compare at +1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_jump(input logic [31:0] tgt, input bit with_call);
    idle(); jump = 1'b1; jump_target = tgt; call = with_call;
    tick();
    idle();
  endtask

  task automatic do_ret(input logic [31:0] fb);
    idle(); ret = 1'b1; ret_fallback = fb;
    tick();
    idle();
  endtask

  logic [31:0] ret_exp [4] = '{32'h51, 32'h41, 32'h31, 32'h21};

  initial begin
    rst_n = 1'b0;
    idle();
    jump = 1'b1; jump_target = 32'h1234; // ignored under reset
    tick(); tick();
    idle();
    check("reset pc", pc, 32'h0);
    check("reset pc_plus1", pc_plus1, 32'h1);
    check("reset empty", 32'(ras_empty), 32'h1);
    check("reset full", 32'(ras_full), 32'h0);
    check("reset ovf", 32'(ras_ovf), 32'h0);

    // Free-running sequential fetch.
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq pc", pc, 32'(i));
    end
    tick(); tick();
    check("pc at 5", pc, 32'h5);

    // Call, two sequential, return.
    do_jump(32'h40, 1'b1);
    check("call target", pc, 32'h40);
    check("call not empty", 32'(ras_empty), 32'h0);
    tick(); tick();
    check("after seq", pc, 32'h42);
    do_ret(32'hDEAD);
    check("ret addr", pc, 32'h6);
    check("ret empty", 32'(ras_empty), 32'h1);

    // Five nested calls overflow a four-entry stack.
    do_jump(32'h10, 1'b0);
    for (int i = 2; i <= 6; i++) do_jump(32'(i * 16), 1'b1);
    check("ovf full", 32'(ras_full), 32'h1);
    check("ovf flag", 32'(ras_ovf), 32'h1);
    for (int i = 0; i < 4; i++) begin
      do_ret(32'h99);
      check("ovf ret", pc, ret_exp[i]);
    end
    do_ret(32'h99);
    check("fallback ret", pc, 32'h99);
    check("fallback empty", 32'(ras_empty), 32'h1);
    check("ovf sticky", 32'(ras_ovf), 32'h1);

    // Branch wins over jump+call and ret; stack must be untouched.
    do_jump(32'h6, 1'b0);
    do_jump(32'h300, 1'b1);            // pushes 0x7
    idle();
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1; jump_target = 32'h200; call = 1'b1;
    ret = 1'b1; ret_fallback = 32'h55;
    tick();
    idle();
    check("prio pc", pc, 32'h100);
    check("prio not full", 32'(ras_full), 32'h0);
    do_ret(32'h55);
    check("prio ras kept", pc, 32'h7);
    check("prio one entry", 32'(ras_empty), 32'h1);

    // Stall overrides jump and ret.
    do_jump(32'h400, 1'b1);            // pushes 0x8
    stall = 1'b1; jump = 1'b1; jump_target = 32'h500; ret = 1'b1; ret_fallback = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall pc", pc, 32'h400);
      check("stall ras", 32'(ras_empty), 32'h0);
    end
    stall = 1'b0;
    tick();
    idle();
    check("post stall jump", pc, 32'h500);
    check("post stall ras", 32'(ras_empty), 32'h0);

    // PC wrap, then reset with two entries held.
    do_jump(32'hFFFF_FFFF, 1'b0);
    check("max pc_plus1", pc_plus1, 32'h0);
    tick();
    check("wrap pc", pc, 32'h0);
    check("wrap pc_plus1", pc_plus1, 32'h1);
    do_jump(32'h20, 1'b1);             // second entry
    rst_n = 1'b0; jump = 1'b1; call = 1'b1; jump_target = 32'h777;
    tick();
    idle();
    rst_n = 1'b1;
    check("mid reset pc", pc, RESET_PC);
    check("mid reset empty", 32'(ras_empty), 32'h1);
    do_ret(32'h99);
    check("reset fallback", pc, 32'h99);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      stall         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      branch_target = $urandom_range(0, 255);
      jump          = ($urandom_range(0, 2) == 0);
      jump_target   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 1023);
      call          = $urandom_range(0, 1) == 1;
      ret           = ($urandom_range(0, 2) == 0);
      ret_fallback  = $urandom;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the fetch stage.
- Holds the word-addressed PC and produces the sequential successor PC+1.
- Selects the next PC from sequential, branch, jump and return sources.
- Contains a small return-address stack (RAS): a call pushes the return address and a return pops it.

Parameters:
- RAS_DEPTH, 4, number of RAS entries; must be a power of 2, ≥2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- stall  input  1  hold PC and RAS; all redirect inputs are ignored.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  32  branch destination (word address).
- jump  input  1  redirect to jump_target.
- jump_target  input  32  jump destination.
- call  input  1  qualifies jump; push PC+1 onto the RAS. Ignored unless jump=1.
- ret  input  1  return; redirect to the RAS top or to ret_fallback.
- ret_fallback  input  32  register-file return address, used when the RAS is empty.
- pc  output  32  current PC (registered).
- pc_plus1  output  32  pc+1, combinational, modulo 2^32.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_ovf  output  1  sticky flag: a push occurred while the RAS was full.

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of other inputs:
  - pc=RESET_PC.
  - RAS count=0, top pointer=0, ras_ovf=0.
  - ras_empty=1, ras_full=0.
  - pc_plus1 = RESET_PC+1 in the same cycle.
- Reset mid-operation discards all RAS contents. Entry storage need not be cleared; unread entries are don't-care.
- pc_plus1 = pc + 1, 32-bit. 32'hFFFF_FFFF wraps to 32'h0000_0000 with no flag.
- Each non-stalled cycle loads next pc with fixed priority:
  1. branch_taken=1 → branch_target.
  2. else jump=1 → jump_target. If call=1, also push pc_plus1.
  3. else ret=1 → if RAS non-empty, RAS top and pop; else ret_fallback with no pop.
  4. else → pc_plus1.
- A lower-priority request that loses arbitration has no side effect:
  - no push when a branch wins over jump+call;
  - no pop when a branch or jump wins over ret.
- Push:
  - Write at top+1 and advance top. count++ if count<RAS_DEPTH.
  - If already full: overwrite the oldest entry (circular) so the newest RAS_DEPTH addresses are kept. count stays RAS_DEPTH and ras_ovf is set to 1.
- Pop: top retreats and count--. The popped value is taken from the current top before the update.
- Latency:
  - Redirect inputs sampled at edge N appear on pc after edge N.
  - ras_empty, ras_full and ras_ovf reflect the post-edge state.
- stall=1: pc, RAS, count and ras_ovf all hold; stall overrides every redirect input.
- ras_ovf clears only on reset.
- RAS state does not depend on pc wrap-around.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- Defined: adds output port redirect_cnt [15:0].
  - Reset to 0.
  - Increments on every non-stalled cycle whose next pc came from branch, jump or ret (not sequential).
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free cycles → pc goes 0,1,2,3; pc_plus1=pc+1; ras_empty=1, ras_full=0, ras_ovf=0.
- At pc=5: assert jump+call with jump_target=0x40, then 2 sequential cycles, then ret → pc goes 0x40,0x41,0x42,6; ras_empty=1 afterwards.
- 5 calls with RAS_DEPTH=4 from pc=0x10,0x20,0x30,0x40,0x50 (each a jump+call to the next address), then 5 rets:
  - ras_full=1 and ras_ovf=1 after the 5th call;
  - rets return 0x51,0x41,0x31,0x21, then ret_fallback=0x99 with ras_empty=1;
  - ras_ovf stays 1.
- Same cycle branch_taken=1 (target 0x100), jump+call=1 (target 0x200), ret=1 with RAS holding 0x7 → pc=0x100; RAS still holds 0x7, count unchanged.
- stall=1 for 3 cycles with jump=1 and ret=1 asserted → pc and RAS unchanged; after stall drops, the jump is taken.
- Set pc to 32'hFFFF_FFFF via jump, then 1 sequential cycle → pc=0, pc_plus1=1. With rst_n=0 mid-sequence while RAS holds 2 entries → pc=RESET_PC, ras_empty=1; a following ret uses ret_fallback.
